p_to_s: RTL and testbench

P_TO_S -- requirements
Module: p_to_s

---
 rtl/p_to_s.sv | 87 ++++++++
 tb/tb_p_to_s.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/p_to_s.sv
// Parallel-to-serial converter: one WIDTH*COUNT frame in, COUNT words out, word 0 first.
// Define P_TO_S_LAST_EN to add the o_last end-of-frame flag.
//
// state | meaning
// IDLE  | no frame held, ready for a new frame
// SHIFT | frame held, emitting word idx (0 .. COUNT-1)
module p_to_s #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH*COUNT-1:0]   i_data,
    input  logic                     i_valid,
    output logic                     i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    input  logic                     o_ready
`ifdef P_TO_S_LAST_EN
    ,
    output logic                     o_last
`endif
);

    localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         idx_nxt;
    logic [WIDTH*COUNT-1:0]   frame;
    logic [WIDTH-1:0]         words [COUNT];
    logic                     at_last;
    logic                     in_xfer;
    logic                     out_xfer;

    for (genvar k = 0; k < COUNT; k++) begin : g_words
        assign words[k] = frame[k*WIDTH +: WIDTH];
    end

    assign idx_nxt  = idx + 1'b1;
    assign at_last  = (state == SHIFT) && (idx == LAST_IDX);
    // A new frame may enter while the last word of the current one leaves.
    assign i_ready  = !rst && ((state == IDLE) || (at_last && o_ready));
    assign in_xfer  = i_valid && i_ready;
    assign out_xfer = o_valid && o_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            frame   <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
`ifdef P_TO_S_LAST_EN
            o_last  <= 1'b0;
`endif
        end else if (in_xfer) begin
            state   <= SHIFT;
            idx     <= '0;
            frame   <= i_data;
            o_data  <= i_data[WIDTH-1:0];
            o_valid <= 1'b1;
`ifdef P_TO_S_LAST_EN
            o_last  <= 1'b0;
`endif
        end else if (out_xfer) begin
            if (at_last) begin
                state   <= IDLE;
                idx     <= '0;
                o_valid <= 1'b0;
`ifdef P_TO_S_LAST_EN
                o_last  <= 1'b0;
`endif
            end else begin
                idx     <= idx_nxt;
                o_data  <= words[idx_nxt];
`ifdef P_TO_S_LAST_EN
                o_last  <= (idx_nxt == LAST_IDX);
`endif
            end
        end
    end

endmodule

// File: tb/tb_p_to_s.sv
// Directed and random-stall checks for p_to_s with WIDTH=8, COUNT=4.
module tb_p_to_s;

    localparam int WIDTH = 8;
    localparam int COUNT = 4;
    localparam logic [31:0] F1 = 32'hEFBEADDE;
    localparam logic [31:0] F2 = 32'h04030201;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      i_data;
    logic             i_valid;
    logic             i_ready;
    logic [7:0]       o_data;
    logic             o_valid;
    logic             o_ready;
`ifdef P_TO_S_LAST_EN
    logic             o_last;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    p_to_s #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready)
`ifdef P_TO_S_LAST_EN
        ,
        .o_last  (o_last)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_last(input string tag, input logic exp);
`ifdef P_TO_S_LAST_EN
        chk(tag, {31'd0, o_last}, {31'd0, exp});
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_word(input string tag, input logic [7:0] w, input logic last);
        chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, o_data}, {24'd0, w});
        chk_last({tag, "_last"}, last);
    endtask

    logic [7:0] exp_w [8];
    logic [7:0] sb [$];
    int         frames_sent;
    int         words_out;
    int         cycles;

    initial begin
        exp_w[0] = 8'hDE; exp_w[1] = 8'hAD; exp_w[2] = 8'hBE; exp_w[3] = 8'hEF;
        exp_w[4] = 8'h01; exp_w[5] = 8'h02; exp_w[6] = 8'h03; exp_w[7] = 8'h04;

        // reset state, no accept while rst high
        rst = 1'b1; i_valid = 1'b1; i_data = F1; o_ready = 1'b1;
        cyc(); cyc();
        #1;
        chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_o_data", {24'd0, o_data}, 32'd0);
        chk_last("rst_o_last", 1'b0);
        i_valid = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        chk("idle_i_ready", {31'd0, i_ready}, 32'd1);
        chk("idle_o_valid", {31'd0, o_valid}, 32'd0);

        // single frame
        i_data = F1; i_valid = 1'b1; o_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            i_valid = 1'b0;
            #1;
            chk_word("single", exp_w[k], k == 3);
            chk("single_i_ready", {31'd0, i_ready}, (k == 3) ? 32'd1 : 32'd0);
        end
        cyc(); #1;
        chk("single_end_valid", {31'd0, o_valid}, 32'd0);

        // back-to-back frames, no bubble
        i_data = F1; i_valid = 1'b1; o_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k == 0) i_data = F2;
            if (k == 4) i_valid = 1'b0;
            #1;
            chk_word("b2b", exp_w[k], k == 3 || k == 7);
            if (k == 3) chk("b2b_i_ready_ef", {31'd0, i_ready}, 32'd1);
        end
        cyc(); #1;
        chk("b2b_end_valid", {31'd0, o_valid}, 32'd0);

        // backpressure on AD
        i_data = F1; i_valid = 1'b1; o_ready = 1'b1;
        cyc(); i_valid = 1'b0; #1;
        chk_word("bp0", 8'hDE, 1'b0);
        cyc();
        o_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_word("bp_hold", 8'hAD, 1'b0);
            chk("bp_i_ready", {31'd0, i_ready}, 32'd0);
            if (k < 2) begin cyc(); #1; end
        end
        cyc();
        o_ready = 1'b1;
        #1;
        chk_word("bp_hold_last", 8'hAD, 1'b0);
        cyc(); #1;
        chk_word("bp_be", 8'hBE, 1'b0);
        cyc(); #1;
        chk_word("bp_ef", 8'hEF, 1'b1);
        cyc(); #1;
        chk("bp_end_valid", {31'd0, o_valid}, 32'd0);

        // second frame offered during SHIFT, stalled at idx 3 briefly
        i_data = F1; i_valid = 1'b1; o_ready = 1'b1;
        cyc(); i_valid = 1'b0; #1;
        chk_word("full_de", 8'hDE, 1'b0);
        cyc();
        i_data = F2; i_valid = 1'b1;
        #1;
        chk_word("full_ad", 8'hAD, 1'b0);
        chk("full_i_ready_idx1", {31'd0, i_ready}, 32'd0);
        cyc(); #1;
        chk_word("full_be", 8'hBE, 1'b0);
        chk("full_i_ready_idx2", {31'd0, i_ready}, 32'd0);
        cyc();
        o_ready = 1'b0;
        #1;
        chk_word("full_ef_stall", 8'hEF, 1'b1);
        chk("full_i_ready_stall", {31'd0, i_ready}, 32'd0);
        cyc();
        o_ready = 1'b1;
        #1;
        chk_word("full_ef", 8'hEF, 1'b1);
        chk("full_i_ready_idx3", {31'd0, i_ready}, 32'd1);
        for (int k = 4; k < 8; k++) begin
            cyc();
            i_valid = 1'b0;
            #1;
            chk_word("full_f2", exp_w[k], k == 7);
        end
        cyc(); #1;
        chk("full_end_valid", {31'd0, o_valid}, 32'd0);

        // reset mid-frame after AD
        i_data = F1; i_valid = 1'b1; o_ready = 1'b1;
        cyc(); i_valid = 1'b0; #1;
        chk_word("mrst_de", 8'hDE, 1'b0);
        cyc(); #1;
        chk_word("mrst_ad", 8'hAD, 1'b0);
        rst = 1'b1;
        #1;
        chk("mrst_i_ready_in_rst", {31'd0, i_ready}, 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mrst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("mrst_i_ready", {31'd0, i_ready}, 32'd1);
        chk("mrst_o_data", {24'd0, o_data}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("mrst_quiet", {31'd0, o_valid}, 32'd0);
        end

        // random stall against scoreboard
        frames_sent = 0; words_out = 0; cycles = 0;
        while ((frames_sent < 1000 || sb.size() != 0) && cycles < 40000) begin
            i_valid = (frames_sent < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            i_data  = $urandom;
            o_ready = ($urandom_range(0, 3) != 0) || (frames_sent >= 1000);
            #1;
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    chk("rand_spurious_word", {24'd0, o_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("rand_word", {24'd0, o_data}, {24'd0, sb.pop_front()});
                    chk_last("rand_last", (words_out % COUNT) == COUNT - 1);
                    words_out++;
                end
            end
            if (i_valid && i_ready) begin
                for (int k = 0; k < COUNT; k++) sb.push_back(i_data[k*8 +: 8]);
                frames_sent++;
            end
            cyc();
            cycles++;
        end
        chk("rand_frames_sent", frames_sent, 32'd1000);
        chk("rand_words_out", words_out, 32'd4000);
        chk("rand_sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
